// File: rtl/mips32_muldiv_pkg.sv
// Shared encodings for the MIPS32 multiply/divide unit.
package mips32_muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2
    } md_state_t;

endpackage

// File: rtl/mips32_muldiv_ctrl.sv
// Sequencer for the multiply/divide unit: FSM, iteration counter,
// busy/done flags and the datapath strobes (load, step, fixup, HI/LO moves).
module mips32_muldiv_ctrl
    import mips32_muldiv_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int CNTW      = $clog2(DATAWIDTH) + 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       flush,
    input  logic [2:0] md_op,
    output logic       busy,
    output logic       done,
    output logic       load,
    output logic       step,
    output logic       fixup,
    output logic       wr_hi,
    output logic       wr_lo
);

    md_state_t       state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Next-state, counter and strobe decode; flush always wins over start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        fixup   = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    if (md_op < MD_MTHI) begin
                        load    = 1'b1;
                        state_d = ST_RUN;
                        cnt_d   = CNTW'(DATAWIDTH - 1);
                    end else if (md_op == MD_MTHI) begin
                        wr_hi = 1'b1;
                    end else if (md_op == MD_MTLO) begin
                        wr_lo = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_FIXUP;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_FIXUP: begin
                state_d = ST_IDLE;
                fixup   = !flush;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = fixup | wr_hi | wr_lo;
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/mips32_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Works on operand magnitudes; signs are reapplied in the FIXUP cycle.
module mips32_muldiv
    import mips32_muldiv_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int CNTW      = $clog2(DATAWIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           MD_op,
    input  logic                 start,
    input  logic                 flush,
    input  logic [DATAWIDTH-1:0] A_in,
    input  logic [DATAWIDTH-1:0] B_in,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] HI_out,
    output logic [DATAWIDTH-1:0] LO_out
);

    localparam int W = DATAWIDTH;

    // Magnitude of a possibly-signed operand; |MIN| wraps to 2^(W-1) unsigned.
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic is_signed);
        return (is_signed && v[W-1]) ? -v : v;
    endfunction

    logic load, step, fixup, wr_hi, wr_lo;

    mips32_muldiv_ctrl #(
        .DATAWIDTH (W),
        .CNTW      (CNTW)
    ) u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .flush (flush),
        .md_op (MD_op),
        .busy  (busy),
        .done  (done),
        .load  (load),
        .step  (step),
        .fixup (fixup),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo)
    );

    // acc: multiply accumulator {partial product, multiplier}; for divide the
    // low half holds the dividend shifting out and the quotient shifting in.
    logic [2*W-1:0] acc_q, acc_d;
    logic [W:0]     rem_q, rem_d;
    logic [W-1:0]   opnd_q, opnd_d;    // multiplicand or divisor magnitude
    logic [W-1:0]   a_raw_q, a_raw_d;  // dividend as given, for divide-by-zero
    logic           op_div_q, op_div_d;
    logic           op_sgn_q, op_sgn_d;
    logic           neg_a_q, neg_a_d;
    logic           neg_b_q, neg_b_d;
    logic           dz_q, dz_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;

    logic           is_sgn_in;
    logic [W:0]     mul_sum;
    logic [W+1:0]   div_shift;
    logic           div_ge;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo, rmd;

    // Datapath: operand capture, one iteration per step, sign fixup and HI/LO writes.
    always_comb begin
        acc_d    = acc_q;
        rem_d    = rem_q;
        opnd_d   = opnd_q;
        a_raw_d  = a_raw_q;
        op_div_d = op_div_q;
        op_sgn_d = op_sgn_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        is_sgn_in = (MD_op == MD_MULT) || (MD_op == MD_DIV);
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
        div_shift = {rem_q, acc_q[W-1]};
        div_ge    = (div_shift >= {2'b00, opnd_q});
        prod      = (op_sgn_q && (neg_a_q ^ neg_b_q)) ? -acc_q : acc_q;
        quo       = (op_sgn_q && (neg_a_q ^ neg_b_q)) ? -acc_q[W-1:0] : acc_q[W-1:0];
        rmd       = (op_sgn_q && neg_a_q) ? -rem_q[W-1:0] : rem_q[W-1:0];

        if (load) begin
            op_div_d = (MD_op == MD_DIV) || (MD_op == MD_DIVU);
            op_sgn_d = is_sgn_in;
            neg_a_d  = is_sgn_in && A_in[W-1];
            neg_b_d  = is_sgn_in && B_in[W-1];
            dz_d     = op_div_d && (B_in == '0);
            a_raw_d  = A_in;
            rem_d    = '0;
            if (op_div_d) begin
                acc_d  = {{W{1'b0}}, magnitude(A_in, is_sgn_in)};
                opnd_d = magnitude(B_in, is_sgn_in);
            end else begin
                acc_d  = {{W{1'b0}}, magnitude(B_in, is_sgn_in)};
                opnd_d = magnitude(A_in, is_sgn_in);
            end
        end else if (step) begin
            if (op_div_q) begin
                rem_d = div_ge ? (W+1)'(div_shift - {2'b00, opnd_q}) : (W+1)'(div_shift);
                acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], div_ge};
            end else begin
                acc_d = {mul_sum, acc_q[W-1:1]};
            end
        end

        if (fixup) begin
            if (!op_div_q) begin
                hi_d = prod[2*W-1:W];
                lo_d = prod[W-1:0];
            end else if (dz_q) begin
                hi_d = a_raw_q;
                lo_d = '1;
            end else begin
                hi_d = rmd;
                lo_d = quo;
            end
        end
        if (wr_hi) hi_d = A_in;
        if (wr_lo) lo_d = A_in;
    end

    // Datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            rem_q    <= '0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            op_div_q <= 1'b0;
            op_sgn_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opnd_q   <= opnd_d;
            a_raw_q  <= a_raw_d;
            op_div_q <= op_div_d;
            op_sgn_q <= op_sgn_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign HI_out = hi_q;
    assign LO_out = lo_q;

endmodule

// File: tb/tb_mips32_muldiv.sv
// Bench for mips32_muldiv (DATAWIDTH=32): directed cases plus randomized ops
// checked every cycle against a behavioural HI/LO/busy/done model.
module tb_mips32_muldiv;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          flush = 1'b0;
    logic [2:0]    MD_op = 3'd7;
    logic [W-1:0]  A_in = '0;
    logic [W-1:0]  B_in = '0;
    logic          busy, done;
    logic [W-1:0]  HI_out, LO_out;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mips32_muldiv #(.DATAWIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .MD_op  (MD_op),
        .start  (start),
        .flush  (flush),
        .A_in   (A_in),
        .B_in   (B_in),
        .busy   (busy),
        .done   (done),
        .HI_out (HI_out),
        .LO_out (LO_out)
    );

    // Architectural result {HI, LO} from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: begin q = sa * sb; return q; end
            3'd1: begin uq = ua * ub; return uq; end
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Behavioural model: pending result appears W+1 edges after acceptance.
    logic         m_busy = 1'b0, m_done = 1'b0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int           m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (flush) begin
                    m_busy <= 1'b0;
                end else if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                    m_done <= 1'b1;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (start && !flush) begin
                if (MD_op < 3'd4) begin
                    {p_hi, p_lo} <= ref_result(MD_op, A_in, B_in);
                    m_busy <= 1'b1;
                    m_left <= W + 1;
                end else if (MD_op == 3'd4) begin
                    m_hi   <= A_in;
                    m_done <= 1'b1;
                end else if (MD_op == 3'd5) begin
                    m_lo   <= A_in;
                    m_done <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("HI", HI_out, m_hi);
            chk("LO", LO_out, m_lo);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
        @(negedge clk);
        start = 1'b1; MD_op = op; A_in = a; B_in = b; flush = fl;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        A_in = $urandom; B_in = $urandom; MD_op = 3'($urandom_range(0, 7));
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    task automatic wait_idle();
        int i = 0;
        while (busy === 1'b1 && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_done();
        int i = 0;
        while (done !== 1'b1 && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic count_cycles(input int n, output int bc, output int dc);
        bc = 0; dc = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bc += int'(busy === 1'b1);
            dc += int'(done === 1'b1);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bc, dc;
        logic [63:0] r;
        logic [2:0] op;

        // Model anchors.
        r = ref_result(3'd0, 32'hFFFF_FFFD, 32'd7);
        chk("ref_mult", r[31:0], 32'hFFFF_FFEB);
        r = ref_result(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("ref_div_min", r[31:0], 32'h8000_0000);

        // Reset values.
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", HI_out, 32'd0);
        chk("rst_lo", LO_out, 32'd0);
        #10 rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        // MULT -3 * 7 with busy/done cycle counts.
        issue(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        count_cycles(40, bc, dc);
        chk("mult_busy_cycles", bc, 32'd33);
        chk("mult_done_pulses", dc, 32'd1);
        chk("mult_hi", HI_out, 32'hFFFF_FFFF);
        chk("mult_lo", LO_out, 32'hFFFF_FFEB);

        // MULTU max*max, then back-to-back start in the done cycle.
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done();
        chk("multu_hi", HI_out, 32'hFFFF_FFFE);
        chk("multu_lo", LO_out, 32'h0000_0001);
        start = 1'b1; MD_op = 3'd1; A_in = 32'd2; B_in = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_idle();
        chk("b2b_hi", HI_out, 32'd0);
        chk("b2b_lo", LO_out, 32'd6);

        // Signed divide cases.
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle();
        chk("div_neg_lo", LO_out, 32'hFFFF_FFFD);
        chk("div_neg_hi", HI_out, 32'hFFFF_FFFF);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle();
        chk("div_min_lo", LO_out, 32'h8000_0000);
        chk("div_min_hi", HI_out, 32'd0);

        // Divide by zero, with latency.
        issue(3'd3, 32'd7, 32'd0, 1'b0);
        count_cycles(40, bc, dc);
        chk("divu0_busy_cycles", bc, 32'd33);
        chk("divu0_lo", LO_out, 32'hFFFF_FFFF);
        chk("divu0_hi", HI_out, 32'd7);
        issue(3'd2, 32'd0, 32'd0, 1'b0);
        wait_idle();
        chk("div00_lo", LO_out, 32'hFFFF_FFFF);
        chk("div00_hi", HI_out, 32'd0);

        // MTHI/MTLO preload, flushed MULT, ignored start while busy.
        issue(3'd4, 32'h11, 32'd0, 1'b0);
        chk("mthi_done", {31'd0, done}, 32'd1);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        issue(3'd5, 32'h22, 32'd0, 1'b0);
        chk("mtlo_done", {31'd0, done}, 32'd1);
        issue(3'd0, 32'd1234, 32'd5678, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1; MD_op = 3'd4; A_in = 32'h99;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        pulse_flush();
        count_cycles(40, bc, dc);
        chk("flush_done_pulses", dc, 32'd0);
        chk("flush_hi", HI_out, 32'h11);
        chk("flush_lo", LO_out, 32'h22);

        // Flush together with start: nothing accepted.
        issue(3'd4, 32'h55, 32'd0, 1'b1);
        chk("flush_start_busy", {31'd0, busy}, 32'd0);
        chk("flush_start_hi", HI_out, 32'h11);

        // Asynchronous reset mid-divide.
        issue(3'd2, 32'd100, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_hi", HI_out, 32'd0);
        chk("arst_lo", LO_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'd1, 32'd5, 32'd6, 1'b0);
        wait_idle();
        chk("post_rst_lo", LO_out, 32'd30);
        chk("post_rst_hi", HI_out, 32'd0);

        // Randomized operations with occasional flushes and stray starts.
        for (int it = 0; it < 60; it++) begin
            op = 3'($urandom_range(0, 7));
            issue(op, pick(), pick(), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1; MD_op = 3'($urandom_range(0, 7)); A_in = $urandom;
                @(posedge clk);
                #1 start = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 34)) @(negedge clk);
                pulse_flush();
            end
            wait_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
